// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage pipeline: merges forwarding
// stall requests, owns the multiply/divide occupancy FSM and applies ID-stage
// branch redirects. Stall/flush controls are combinational (zero latency).
// Optional feature macro: HAZARD_PERF_CNT_EN builds saturating stall/flush
// performance counters; without it both counter ports are tied to zero.
module pipeline_hazard_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_fwd_stall,
  input  logic        ex_fwd_stall,
  input  logic        md_start,
  input  logic        md_is_div,
  input  logic        ex_reads_hilo,
  input  logic        branch_taken_id,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        ex_mem_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PERF_W = 32;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_MD_RUN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_md_hazard;
  logic               w_ex_stall;
  logic               w_id_stall;
  logic               w_branch_flush;

  // MDU state and occupancy counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Hazard resolution, write enables/flushes and MDU next state
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    md_busy        = 1'b0;
    md_done        = 1'b0;
    w_md_hazard    = 1'b0;
    w_ex_stall     = 1'b0;
    w_id_stall     = 1'b0;
    w_branch_flush = 1'b0;
    pc_we          = 1'b1;
    if_id_we       = 1'b1;
    id_ex_we       = 1'b1;
    ex_mem_we      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;

    // Reset holds every control neutral
    if (reset_n) begin
      md_busy        = (r_state == S_MD_RUN);
      md_done        = md_busy && (r_cnt == CNT_W'(1));
      w_md_hazard    = (md_start | ex_reads_hilo) & md_busy;
      w_ex_stall     = ex_fwd_stall | w_md_hazard;
      w_id_stall     = id_fwd_stall & ~w_ex_stall;
      w_branch_flush = branch_taken_id & ~w_ex_stall & ~w_id_stall;

      if (w_ex_stall) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_flush = 1'b1;
      end else if (w_id_stall) begin
        pc_we        = 1'b0;
        if_id_we     = 1'b0;
        id_ex_flush  = 1'b1;
      end else if (w_branch_flush) begin
        if_id_flush  = 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (md_start && !w_ex_stall) begin
            w_state_nxt = S_MD_RUN;
            w_cnt_nxt   = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          end
        end
        S_MD_RUN: begin
          // cnt==0 is unreachable; treat it as completion for robustness
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_perf_stall;
  logic [PERF_W-1:0] r_perf_flush;
  logic              w_any_flush;

  assign w_any_flush = if_id_flush | id_ex_flush | ex_mem_flush;

  // Saturating stall-cycle and flush-cycle counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if ((w_ex_stall || w_id_stall) && (r_perf_stall != '1))
        r_perf_stall <= r_perf_stall + PERF_W'(1);
      if (w_any_flush && (r_perf_flush != '1))
        r_perf_flush <= r_perf_flush + PERF_W'(1);
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_flush_count  = r_perf_flush;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: constant vector table,
// hand-written multi-cycle sequences and random stimulus against a
// remaining-cycles reference model. Honours HAZARD_PERF_CNT_EN.
module tb_pipeline_hazard_controller;

  localparam int MUL_N = 4;
  localparam int DIV_N = 32;

  logic        clk = 1'b0;
  logic        reset_n, id_fwd_stall, ex_fwd_stall, md_start, md_is_div;
  logic        ex_reads_hilo, branch_taken_id;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done;
  logic [31:0] perf_stall_cycles, perf_flush_count;

  pipeline_hazard_controller #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .id_fwd_stall(id_fwd_stall),
    .ex_fwd_stall(ex_fwd_stall), .md_start(md_start), .md_is_div(md_is_div),
    .ex_reads_hilo(ex_reads_hilo), .branch_taken_id(branch_taken_id),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .md_busy(md_busy), .md_done(md_done),
    .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
  );

  always #5 clk = ~clk;

  // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_fl, id_ex_fl, ex_mem_fl, busy, done}
  logic [8:0] dut_vec;
  assign dut_vec = {pc_we, if_id_we, id_ex_we, ex_mem_we,
                    if_id_flush, id_ex_flush, ex_mem_flush, md_busy, md_done};

  typedef struct packed {
    logic       rn, idf, exf, ms, dv, hl, br;
    logic [8:0] exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          m_left = 0;          // MDU cycles still to run
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;
  logic [8:0]  obs;                 // DUT outputs seen in the last step

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs, checks outputs mid-cycle, advances the model.
  task automatic step(input logic rn, idf, exf, ms, dv, hl, br,
                      input logic use_tbl = 1'b0, input logic [8:0] tbl_exp = '0);
    logic busy, done, exs, ids, b;
    logic [8:0]  exp;
    logic [63:0] perf_exp;
    reset_n = rn; id_fwd_stall = idf; ex_fwd_stall = exf; md_start = ms;
    md_is_div = dv; ex_reads_hilo = hl; branch_taken_id = br;
    #4;
    busy = rn && (m_left > 0);
    done = busy && (m_left == 1);
    exs  = rn && (exf || ((ms || hl) && busy));
    ids  = rn && idf && !exs;
    b    = rn && br && !exs && !ids;
    exp  = {!(exs || ids), !(exs || ids), !exs, 1'b1, b, ids, exs, busy, done};
    if (use_tbl) exp = tbl_exp;
`ifdef HAZARD_PERF_CNT_EN
    perf_exp = {m_stall, m_flush};
`else
    perf_exp = '0;
`endif
    obs = dut_vec;
    check(use_tbl ? "table_outs" : "model_outs", 64'(dut_vec), 64'(exp));
    check("perf", {perf_stall_cycles, perf_flush_count}, perf_exp);
    if (!rn) begin
      m_left = 0; m_stall = '0; m_flush = '0;
    end else begin
      if ((exs || ids) && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if ((exs || ids || b) && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
      if (busy) m_left = m_left - 1;
      else if (ms && !exs) m_left = dv ? DIV_N : MUL_N;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(); step(1, 0, 0, 0, 0, 0, 0); endtask
  task automatic do_reset(); step(0, 0, 0, 0, 0, 0, 0); endtask

  vec_t tbl [10];
  int   busy_n, done_n, done_at, flush_n;
  logic [15:0] done_mask;

  initial begin
    reset_n = 0; id_fwd_stall = 0; ex_fwd_stall = 0; md_start = 0;
    md_is_div = 0; ex_reads_hilo = 0; branch_taken_id = 0;
    @(posedge clk); #1;

    //              rn idf exf ms dv hl br  pc ii ie em fii fie fem bz dn
    tbl[0] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 9'b1111_000_00};
    tbl[1] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 9'b1111_000_00};
    tbl[2] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 9'b0011_010_00};
    tbl[3] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 9'b0001_001_00};
    tbl[4] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 9'b1111_100_00};
    tbl[5] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 9'b0011_010_00};
    tbl[6] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1, 9'b0001_001_00};
    tbl[7] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 9'b1111_000_00};
    tbl[8] = '{1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0, 9'b0001_001_00};
    tbl[9] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0, 9'b0001_001_00};
    for (int i = 0; i < 10; i++)
      step(tbl[i].rn, tbl[i].idf, tbl[i].exf, tbl[i].ms, tbl[i].dv,
           tbl[i].hl, tbl[i].br, 1'b1, tbl[i].exp);
    // the start blocked by ex_fwd_stall in tbl[8] must not have been taken
    idle();
    check("start_blocked_by_exfwd", 64'(obs[1]), 64'd0);

    // Branch held by an ID stall is flushed in the first free cycle
    step(1, 1, 0, 0, 0, 0, 1);
    check("held_branch_stall", 64'({obs[4], obs[3]}), 64'b01);
    step(1, 0, 0, 0, 0, 0, 1);
    check("held_branch_release", 64'(obs[4]), 64'd1);

    // Divide followed by mflo waiting in EX
    idle();
    step(1, 0, 0, 1, 1, 0, 0);
    busy_n = 0; done_n = 0; done_at = -1; flush_n = 0;
    for (int k = 1; k <= DIV_N + 1; k++) begin
      step(1, 0, 0, 0, 0, 1, 0);
      busy_n  += int'(obs[1]);
      flush_n += int'(obs[2]);
      if (obs[0]) begin done_n++; done_at = k; end
    end
    check("div_busy_cycles", 64'(busy_n), 64'(DIV_N));
    check("div_done_once_last", 64'({done_n, done_at}), {32'd1, 32'(DIV_N)});
    check("mflo_stall_cycles", 64'(flush_n), 64'(DIV_N));
    check("mflo_advances", 64'(obs[2]), 64'd0);

    // Back-to-back multiplies: second held in EX until the first finishes
    idle();
    step(1, 0, 0, 1, 0, 0, 0);
    done_mask = '0;
    for (int k = 1; k <= 10; k++) begin
      step(1, 0, 0, (k <= MUL_N + 1), 0, 0, 0);
      done_mask[k] = obs[0];
    end
    check("mult_b2b_done_cycles", 64'(done_mask), 64'(16'b0000_0010_0001_0000));

    // Reset in the middle of a divide aborts without md_done
    step(1, 0, 0, 1, 1, 0, 0);
    for (int k = 0; k < 15; k++) idle();
    do_reset();
    done_n = 0; busy_n = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      done_n += int'(obs[0]);
      busy_n += int'(obs[1]);
    end
    check("abort_no_busy_no_done", 64'({busy_n, done_n}), 64'd0);

    // Performance counters: 3 ID stalls and 1 branch flush
    do_reset();
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    #4;
`ifdef HAZARD_PERF_CNT_EN
    check("perf_3stall_1br", {perf_stall_cycles, perf_flush_count}, {32'd3, 32'd4});
`else
    check("perf_absent", {perf_stall_cycles, perf_flush_count}, 64'd0);
`endif
    #1;
    @(posedge clk); #1;
    m_stall = '0; m_flush = '0;
    do_reset();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      step(($urandom_range(0, 79) != 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
